// File: rtl/level_select_multi_pkg.sv
// Shared types and helpers for the level selector: FSM states, index width, one-hot decode.
package level_select_pkg;

  typedef enum logic [1:0] {
    S_RSTPULSE,
    S_SELECT,
    S_LOCKED
  } state_e;

  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

  // 1-based index of the set bit; 0 when no bit is set. Covers up to 8 levels.
  function automatic logic [3:0] oh2idx(input logic [7:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = 4'(i + 1);
    return idx;
  endfunction

endpackage

// File: rtl/level_select_multi_if.sv
// Keypad-in / level-out bundle of the level selector; slave side is the selector.
interface level_select_multi_if #(parameter int NUM_LEVELS = 3);
  import level_select_pkg::*;
  localparam int IDX_W = idx_width(NUM_LEVELS);

  logic [NUM_LEVELS-1:0] keypad_lvl;
  logic                  keypad_clr;
  logic [NUM_LEVELS-1:0] level;
  logic [IDX_W-1:0]      level_idx;
  logic                  end_signal;
  logic                  game_rst_n;
  logic                  err_multi;

  modport master (
    output keypad_lvl, keypad_clr,
    input  level, level_idx, end_signal, game_rst_n, err_multi
  );

  modport slave (
    input  keypad_lvl, keypad_clr,
    output level, level_idx, end_signal, game_rst_n, err_multi
  );
endinterface

// File: rtl/level_select_multi_key_debounce.sv
// One keypad key: 2-FF synchroniser, stable-sample debounce, registered one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      level_o <= 1'b0;
      level_d <= 1'b0;
      press_o <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level_o;
      press_o <= level_o & ~level_d;
      // Any sample that agrees with the current state restarts the run.
      if (sync[1] != level_o) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_o <= sync[1];
          cnt     <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/level_select_multi.sv
// Difficulty selector: debounces level/clear keys, latches one unambiguous level, drives game reset.
// Optional LEVEL_SELECT_TIMEOUT_EN auto-selects DEFAULT_LEVEL after TIMEOUT_CYCLES in S_SELECT.
module level_select_multi
  import level_select_pkg::*;
#(
  parameter int NUM_LEVELS       = 3,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int RST_PULSE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES   = 1000,
  parameter int DEFAULT_LEVEL    = 1
) (
  input logic clk,
  input logic rst_n,
  level_select_multi_if.slave bus
);
  localparam int IDX_W = idx_width(NUM_LEVELS);
  localparam int RPW   = $clog2(RST_PULSE_CYCLES + 1);

  // Bit 0 is the clear key, bits NUM_LEVELS:1 are level keys 1..N.
  logic [NUM_LEVELS:0] raw_all, db, ev;

  assign raw_all = {bus.keypad_lvl, bus.keypad_clr};

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key [NUM_LEVELS:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (raw_all),
    .level_o (db),
    .press_o (ev)
  );

  logic [NUM_LEVELS-1:0] lvl_ev, lvl_db;
  logic                  clr_ev, lone, err;
  logic                  unused_clr_db;

  assign lvl_ev        = ev[NUM_LEVELS:1];
  assign lvl_db        = db[NUM_LEVELS:1];
  assign clr_ev        = ev[0];
  assign unused_clr_db = db[0];
  assign lone          = ($countones(lvl_ev) == 1) && ((lvl_db & ~lvl_ev) == '0);

  state_e                state_q, state_d;
  logic [RPW-1:0]        rp_cnt_q, rp_cnt_d;
  logic [NUM_LEVELS-1:0] level_q, level_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  end_q, end_d;

`ifdef LEVEL_SELECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  localparam int unused_tmo_cfg = TIMEOUT_CYCLES + DEFAULT_LEVEL;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RSTPULSE;
      rp_cnt_q <= '0;
      level_q  <= '0;
      idx_q    <= '0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rp_cnt_q <= rp_cnt_d;
      level_q  <= level_d;
      idx_q    <= idx_d;
      end_q    <= end_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    level_d  = level_q;
    idx_d    = idx_q;
    end_d    = end_q;
    err      = 1'b0;
`ifdef LEVEL_SELECT_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    // Clear outranks everything, including a same-cycle level press.
    if (clr_ev) begin
      state_d  = S_RSTPULSE;
      rp_cnt_d = '0;
      level_d  = '0;
      idx_d    = '0;
      end_d    = 1'b0;
    end else begin
      case (state_q)
        S_RSTPULSE: begin
          if (rp_cnt_q == RPW'(RST_PULSE_CYCLES - 1)) begin
            state_d  = S_SELECT;
            rp_cnt_d = '0;
`ifdef LEVEL_SELECT_TIMEOUT_EN
            tmo_d    = '0;
`endif
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
        S_SELECT: begin
          if (lvl_ev != '0) begin
            if (lone) begin
              state_d = S_LOCKED;
              level_d = lvl_ev;
              idx_d   = IDX_W'(oh2idx(8'(lvl_ev)));
              end_d   = 1'b1;
            end else begin
              err = 1'b1;
`ifdef LEVEL_SELECT_TIMEOUT_EN
              tmo_d = '0;
`endif
            end
          end
`ifdef LEVEL_SELECT_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_LOCKED;
            level_d = NUM_LEVELS'(1) << (DEFAULT_LEVEL - 1);
            idx_d   = IDX_W'(DEFAULT_LEVEL);
            end_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
        S_LOCKED: ;
        default: state_d = S_RSTPULSE;
      endcase
    end
  end

  assign bus.level      = level_q;
  assign bus.level_idx  = idx_q;
  assign bus.end_signal = end_q;
  assign bus.game_rst_n = (state_q != S_RSTPULSE);
  assign bus.err_multi  = err;

endmodule
